// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the program counter and sequences instruction fetch
// around control-flow redirects.
//  - RUN advances the PC by 4 per cycle and holds it on a hazard stall.
//  - An aligned jump/branch redirect loads the target and then raises flush
//    for FLUSH_DEPTH cycles.
//  - A misaligned target halts the sequencer until reset.
// Optional feature: define PC_SEQ_REDIRECT_CNT_EN to add a 16-bit saturating
// counter (redirect_cnt) of accepted, aligned redirects. Without the macro,
// that port and its counter do not exist.
module pc_sequencer #(
  parameter int unsigned          DATA_W      = 16,
  parameter logic [DATA_W-1:0]    PC_RESET    = '0,
  parameter int unsigned          FLUSH_DEPTH = 2
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              stall,
  input  logic              pc_src,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] jump_pc,
  output logic [DATA_W-1:0] current_pc,
  output logic [DATA_W-1:0] updated_pc,
  output logic              pc_valid,
  output logic              flush,
  output logic              misalign_err,
  output logic [1:0]        state
`ifdef PC_SEQ_REDIRECT_CNT_EN
  ,
  output logic [15:0]       redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  // The flush counter is loaded with the number of flush cycles still
  // remaining after the first one, so a depth of 1 loads 0.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_pc;
  logic              r_pc_valid;
  logic              r_flush;
  logic              r_misalign_err;
  logic [2:0]        r_flush_cnt;

  logic              w_redirect;
  logic [DATA_W-1:0] w_target;
  logic              w_misaligned;
  logic              w_accept_redirect;
  logic [DATA_W-1:0] w_pc_plus4;

  // Redirect decode. Jump takes priority over a taken branch.
  assign w_redirect        = jump | pc_src;
  assign w_target          = jump ? jump_pc : branch_pc;
  assign w_misaligned      = |w_target[1:0];
  assign w_accept_redirect = (r_state == ST_RUN) && enable && w_redirect && !w_misaligned;

  // NOTE: the sum is cast to DATA_W on purpose, so 0xFFFC + 4 wraps to 0.
  assign w_pc_plus4 = r_pc + DATA_W'(4);

  assign current_pc   = r_pc;
  assign updated_pc   = w_pc_plus4;
  assign pc_valid     = r_pc_valid;
  assign flush        = r_flush;
  assign misalign_err = r_misalign_err;
  assign state        = r_state;

  // Main sequencer FSM. It registers the PC, the state and every status output.
  // NOTE: all state uses non-blocking assignments, so each branch reads
  // pre-edge values no matter what order the branches are written in.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state        <= ST_IDLE;
      r_pc           <= PC_RESET;
      r_pc_valid     <= 1'b0;
      r_flush        <= 1'b0;
      r_misalign_err <= 1'b0;
      r_flush_cnt    <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state    <= ST_RUN;
            r_pc_valid <= 1'b1;
          end
        end

        ST_RUN: begin
          if (!enable) begin
            r_state    <= ST_IDLE;
            r_pc_valid <= 1'b0;
          end else if (w_redirect) begin
            if (w_misaligned) begin
              r_state        <= ST_HALT;
              r_misalign_err <= 1'b1;
              r_pc_valid     <= 1'b0;
            end else begin
              r_pc        <= w_target;
              r_state     <= ST_FLUSH;
              r_flush     <= 1'b1;
              r_flush_cnt <= FLUSH_LOAD;
            end
          end else if (!stall) begin
            r_pc <= w_pc_plus4;
          end
        end

        ST_FLUSH: begin
          // Redirect inputs come from wrong-path instructions here. They are
          // ignored, and the flush length is fixed once it has started.
          if (!stall) begin
            r_pc <= w_pc_plus4;
          end
          if (r_flush_cnt == 3'd0) begin
            r_flush <= 1'b0;
            if (enable) begin
              r_state <= ST_RUN;
            end else begin
              r_state    <= ST_IDLE;
              r_pc_valid <= 1'b0;
            end
          end else begin
            r_flush_cnt <= r_flush_cnt - 3'd1;
          end
        end

        ST_HALT: begin
          // Terminal state. Only reset leaves it.
          r_pc_valid <= 1'b0;
          r_flush    <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PC_SEQ_REDIRECT_CNT_EN
  logic [15:0] r_redirect_cnt;

  assign redirect_cnt = r_redirect_cnt;

  // Saturating count of accepted, aligned redirects.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_redirect_cnt <= 16'd0;
    end else if (w_accept_redirect && (r_redirect_cnt != 16'hFFFF)) begin
      r_redirect_cnt <= r_redirect_cnt + 16'd1;
    end
  end
`else
  // The acceptance term only feeds the optional counter. Without the counter,
  // fold it into a wire that nothing reads so the decode stays the same.
  logic w_unused_accept;
  assign w_unused_accept = w_accept_redirect;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. It applies a table of stimulus records with
// expected next-cycle outputs, then runs hand-written reset corner cases.
// Expected values pass through a scoreboard queue from drive to compare.
// Define PC_SEQ_REDIRECT_CNT_EN to also check redirect_cnt.
module tb_pc_sequencer;

  logic        clk;
  logic        arst_n;
  logic        enable;
  logic        stall;
  logic        pc_src;
  logic        jump;
  logic [15:0] branch_pc;
  logic [15:0] jump_pc;
  logic [15:0] current_pc;
  logic [15:0] updated_pc;
  logic        pc_valid;
  logic        flush;
  logic        misalign_err;
  logic [1:0]  state;
`ifdef PC_SEQ_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] pc;
    logic        valid;
    logic        fl;
    logic        err;
    logic [1:0]  st;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic        en;
    logic        stl;
    logic        ps;
    logic        jp;
    logic [15:0] bpc;
    logic [15:0] jpc;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];

  pc_sequencer #(
    .DATA_W      (16),
    .PC_RESET    (16'h0000),
    .FLUSH_DEPTH (2)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .enable       (enable),
    .stall        (stall),
    .pc_src       (pc_src),
    .jump         (jump),
    .branch_pc    (branch_pc),
    .jump_pc      (jump_pc),
    .current_pc   (current_pc),
    .updated_pc   (updated_pc),
    .pc_valid     (pc_valid),
    .flush        (flush),
    .misalign_err (misalign_err),
    .state        (state)
`ifdef PC_SEQ_REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [15:0] pc, input logic valid, input logic fl,
                                  input logic err, input logic [1:0] st, input logic [15:0] cnt);
    exp_t e;
    e.pc = pc; e.valid = valid; e.fl = fl; e.err = err; e.st = st; e.cnt = cnt;
    return e;
  endfunction

  function automatic vec_t v(input logic en, input logic stl, input logic ps, input logic jp,
                             input logic [15:0] bpc, input logic [15:0] jpc,
                             input logic [15:0] pc, input logic valid, input logic fl,
                             input logic err, input logic [1:0] st, input logic [15:0] cnt);
    vec_t t;
    t.en = en; t.stl = stl; t.ps = ps; t.jp = jp; t.bpc = bpc; t.jpc = jpc;
    t.e = mk_exp(pc, valid, fl, err, st, cnt);
    return t;
  endfunction

  task automatic compare(input string tag, input exp_t e);
    logic [15:0] exp_upd;
    exp_upd = e.pc + 16'd4;
    check({tag, ".current_pc"}, 32'(current_pc), 32'(e.pc));
    check({tag, ".updated_pc"}, 32'(updated_pc), 32'(exp_upd));
    check({tag, ".pc_valid"}, 32'(pc_valid), 32'(e.valid));
    check({tag, ".flush"}, 32'(flush), 32'(e.fl));
    check({tag, ".misalign_err"}, 32'(misalign_err), 32'(e.err));
    check({tag, ".state"}, 32'(state), 32'(e.st));
`ifdef PC_SEQ_REDIRECT_CNT_EN
    check({tag, ".redirect_cnt"}, 32'(redirect_cnt), 32'(e.cnt));
`endif
  endtask

  // Drive one record between edges, let one rising edge pass, then compare.
  task automatic apply(input vec_t t, input string tag);
    exp_t e;
    @(negedge clk);
    enable    = t.en;
    stall     = t.stl;
    pc_src    = t.ps;
    jump      = t.jp;
    branch_pc = t.bpc;
    jump_pc   = t.jpc;
    sb_q.push_back(t.e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    compare(tag, e);
  endtask

  // Pulse reset between edges and check the outputs before any clock edge.
  task automatic pulse_reset_and_check(input string tag);
    @(negedge clk);
    #2;
    arst_n = 1'b0;
    #1;
    compare(tag, mk_exp(16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
    @(negedge clk);
    enable = 1'b0; stall = 1'b0; pc_src = 1'b0; jump = 1'b0;
    arst_n = 1'b1;
  endtask

  initial begin
    arst_n    = 1'b0;
    enable    = 1'b0;
    stall     = 1'b0;
    pc_src    = 1'b0;
    jump      = 1'b0;
    branch_pc = 16'h0000;
    jump_pc   = 16'h0000;

    //          en st ps jp  bpc       jpc       pc        vld fl er st cnt
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 0));  // 0 IDLE->RUN
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 1, 0, 0, 1, 0));  // 1
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0008, 1, 0, 0, 1, 0));  // 2
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h000C, 1, 0, 0, 1, 0));  // 3
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0010, 1, 0, 0, 1, 0));  // 4
    vecs.push_back(v(1, 0, 1, 0, 16'h0040, 16'h0000, 16'h0040, 1, 1, 0, 2, 1));  // 5 branch
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0044, 1, 1, 0, 2, 1));  // 6 flush 2
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0048, 1, 0, 0, 1, 1));  // 7 back to RUN
    vecs.push_back(v(1, 1, 1, 1, 16'h0080, 16'h0100, 16'h0100, 1, 1, 0, 2, 2));  // 8 jump+br+stall
    vecs.push_back(v(1, 0, 1, 0, 16'h0200, 16'h0000, 16'h0104, 1, 1, 0, 2, 2));  // 9 ignored br
    vecs.push_back(v(1, 0, 1, 0, 16'h0200, 16'h0000, 16'h0108, 1, 0, 0, 1, 2));  // 10 ignored br
    vecs.push_back(v(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0108, 1, 0, 0, 1, 2));  // 11 stall
    vecs.push_back(v(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0108, 0, 0, 0, 0, 2));  // 12 ->IDLE
    vecs.push_back(v(0, 0, 1, 0, 16'h0300, 16'h0000, 16'h0108, 0, 0, 0, 0, 2));  // 13 idle hold
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0108, 1, 0, 0, 1, 2));  // 14 ->RUN
    vecs.push_back(v(1, 0, 1, 0, 16'h0108, 16'h0000, 16'h0108, 1, 1, 0, 2, 3));  // 15 self redirect
    vecs.push_back(v(0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0108, 1, 1, 0, 2, 3));  // 16 flush stall
    vecs.push_back(v(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h010C, 0, 0, 0, 0, 3));  // 17 flush->IDLE
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h010C, 1, 0, 0, 1, 3));  // 18
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0110, 1, 0, 0, 1, 3));  // 19
    vecs.push_back(v(1, 0, 0, 1, 16'h0000, 16'hFFF0, 16'hFFF0, 1, 1, 0, 2, 4));  // 20 jump high
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFF4, 1, 1, 0, 2, 4));  // 21
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFF8, 1, 0, 0, 1, 4));  // 22
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'hFFFC, 1, 0, 0, 1, 4));  // 23 upd wraps
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 4));  // 24 pc wraps
    vecs.push_back(v(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 4));  // 25 stall x3
    vecs.push_back(v(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 4));  // 26
    vecs.push_back(v(1, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 4));  // 27
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 1, 0, 0, 1, 4));  // 28
    vecs.push_back(v(1, 0, 1, 0, 16'h0042, 16'h0000, 16'h0004, 0, 0, 1, 3, 4));  // 29 misaligned
    vecs.push_back(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 0, 0, 1, 3, 4));  // 30 halt holds
    vecs.push_back(v(1, 0, 0, 1, 16'h0000, 16'h0080, 16'h0004, 0, 0, 1, 3, 4));  // 31 halt holds

    #12;
    compare("reset", mk_exp(16'h0000, 1'b0, 1'b0, 1'b0, 2'd0, 16'd0));
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // A reset pulse in the middle of HALT clears everything at once.
    pulse_reset_and_check("halt_reset");

    // When both are high, jump wins, so the misaligned jump halts even though
    // the branch target is aligned.
    apply(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 0), "jw_run");
    apply(v(1, 0, 1, 1, 16'h0040, 16'h0081, 16'h0000, 0, 0, 1, 3, 0), "jw_halt");
    pulse_reset_and_check("jw_reset");

    // A reset in the middle of FLUSH leaves no partial flush state.
    apply(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 0), "fr_run");
    apply(v(1, 0, 1, 0, 16'h0020, 16'h0000, 16'h0020, 1, 1, 0, 2, 1), "fr_flush");
    pulse_reset_and_check("flush_reset");
    apply(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 0), "fr_rerun");
    apply(v(1, 0, 0, 0, 16'h0000, 16'h0000, 16'h0004, 1, 0, 0, 1, 0), "fr_seq");

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
